// File: rtl/dense_pkg.sv
// dense_pkg: shared state encoding, index-width helpers and output shaping for dense_layer_seq
package dense_pkg;
   typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;
   localparam int SAT_W = 128;
   typedef logic signed [SAT_W-1:0] wide_t;
   function automatic int groups(input int rows, input int lanes);
      return (rows + lanes - 1) / lanes;
   endfunction
   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   function automatic wide_t sat_relu(input wide_t s, input logic relu_en, input int data_w, input int frac);
      wide_t y, hi, lo;
      y = s >>> frac;
      hi = (wide_t'(1) <<< (data_w - 1)) - wide_t'(1);
      lo = ~hi;
      y = (relu_en && y[SAT_W-1]) ? '0 : y;
      return (y > hi) ? hi : (y < lo) ? lo : y;
   endfunction
endpackage

// File: rtl/mac_lane.sv
// mac_lane: one signed multiply-accumulate lane with a wide accumulator
module mac_lane #(
   parameter int DATA_W = 16,
   parameter int ACC_W = 37
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [ACC_W-1:0] acc
);
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   // full-width product, sign-extended into the accumulator
   always_comb begin
      prod = a * b;
      acc_d = clear ? '0 : en ? acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod} : acc_q;
      acc = acc_q;
   end
   // accumulator register
   always_ff @(posedge clk) acc_q <= rst ? '0 : acc_d;
endmodule

// File: rtl/dense_layer_seq.sv
// dense_layer_seq: multi-cycle act(W*x + b) with LANES parallel MAC lanes, scaling and saturation
module dense_layer_seq
   import dense_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ROWS = 16,
   parameter int COLS = 16,
   parameter int LANES = 4,
   parameter int FRAC = 8,
   parameter int ACC_W = 2 * DATA_W + $clog2(COLS) + 1
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic ready,
   input  logic relu_en,
   input  logic [ROWS*COLS*DATA_W-1:0] mat1,
   input  logic [COLS*DATA_W-1:0] vec,
   input  logic [ROWS*DATA_W-1:0] bias,
   output logic [ROWS*DATA_W-1:0] out,
   output logic out_valid,
   input  logic out_ready
);
   localparam int RW = idx_w(ROWS);
   localparam int CW = idx_w(COLS);
   state_t state_q, state_d;
   logic [RW-1:0] rb_q, rb_d;
   logic [CW-1:0] col_q, col_d;
   logic relu_q, relu_d, clr, en;
   logic signed [DATA_W-1:0] m_q [ROWS][COLS], m_d [ROWS][COLS];
   logic signed [DATA_W-1:0] v_q [COLS], v_d [COLS];
   logic signed [DATA_W-1:0] b_q [ROWS], b_d [ROWS];
   logic signed [DATA_W-1:0] out_q [ROWS], out_d [ROWS];
   logic signed [DATA_W-1:0] y [LANES];
   logic signed [ACC_W-1:0] acc [LANES];
   logic [RW-1:0] ri [LANES];
   logic lv [LANES];
   wide_t s [LANES];
   // sequencing: capture on accept, walk columns per row group, write, then hold result
   always_comb begin
      state_d = state_q;
      rb_d = rb_q;
      col_d = col_q;
      relu_d = relu_q;
      m_d = m_q;
      v_d = v_q;
      b_d = b_q;
      clr = 1'b0;
      en = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = MAC;
            rb_d = '0;
            col_d = '0;
            clr = 1'b1;
            relu_d = relu_en;
            for (int r = 0; r < ROWS; r++)
               for (int c = 0; c < COLS; c++) m_d[r][c] = mat1[(r*COLS+c)*DATA_W +: DATA_W];
            for (int c = 0; c < COLS; c++) v_d[c] = vec[c*DATA_W +: DATA_W];
            for (int r = 0; r < ROWS; r++) b_d[r] = bias[r*DATA_W +: DATA_W];
         end
         MAC: begin
            en = 1'b1;
            col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
            state_d = (col_q == CW'(COLS - 1)) ? WRITE : MAC;
         end
         WRITE: if (int'(rb_q) + LANES >= ROWS) state_d = DONE;
         else begin
            state_d = MAC;
            rb_d = rb_q + RW'(LANES);
            col_d = '0;
            clr = 1'b1;
         end
         DONE: state_d = out_ready ? IDLE : DONE;
      endcase
   end
   // per-lane row mapping and bias/shift/ReLU/saturate of the finished accumulator
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lv[l] = int'(rb_q) + l < ROWS;
         ri[l] = lv[l] ? rb_q + RW'(l) : '0;
         s[l] = wide_t'(acc[l]) + (wide_t'(b_q[ri[l]]) <<< FRAC);
         y[l] = DATA_W'(sat_relu(s[l], relu_q, DATA_W, FRAC));
      end
   end
   // WRITE steers each valid lane into its output row
   always_comb begin
      out_d = out_q;
      for (int r = 0; r < ROWS; r++)
         for (int l = 0; l < LANES; l++)
            if (state_q == WRITE && lv[l] && ri[l] == RW'(r)) out_d[r] = y[l];
   end
   // status and flattened result
   always_comb begin
      ready = state_q == IDLE;
      out_valid = state_q == DONE;
      for (int r = 0; r < ROWS; r++) out[r*DATA_W +: DATA_W] = out_q[r];
   end
   // control state and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rb_q <= '0;
         col_q <= '0;
         relu_q <= 1'b0;
         out_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         rb_q <= rb_d;
         col_q <= col_d;
         relu_q <= relu_d;
         out_q <= out_d;
      end
   end
   // operand capture registers
   always_ff @(posedge clk) begin
      m_q <= m_d;
      v_q <= v_d;
      b_q <= b_d;
   end
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
         .clk(clk),
         .rst(rst),
         .clear(clr),
         .en(en && lv[l]),
         .a(m_q[ri[l]][col_q]),
         .b(v_q[col_q]),
         .acc(acc[l])
      );
   end
endmodule

// File: tb/tb_dense_layer_seq.sv
// tb_dense_layer_seq: three configurations checked against a cycle-budget and arithmetic model
module tb_dense_layer_seq;
   localparam int RR [3] = '{4, 4, 5};
   localparam int CC [3] = '{4, 4, 3};
   localparam int FF [3] = '{0, 8, 0};
   localparam int LN = 2;
   logic clk = 1'b0, rst = 1'b1, armed = 1'b0;
   always #5 clk = ~clk;
   logic st [3], ordy [3], rl [3], rdy [3], ov [3];
   logic signed [15:0] w [5][4], x [4], b [5], ex [5];
   logic [255:0] m0, m1;
   logic [239:0] m2;
   logic [63:0] v0, v1, b0, b1, o0, o1;
   logic [47:0] v2;
   logic [79:0] b2, o2;
   logic signed [15:0] o_all [3][5];
   int total = 0, bad = 0;
   int cnt [3];
   bit busy [3], val [3];
   logic signed [15:0] pend [3][5], eo [3][5];

   always_comb begin
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            m0[(r*4+c)*16 +: 16] = w[r][c];
            m1[(r*4+c)*16 +: 16] = w[r][c];
         end
         b0[r*16 +: 16] = b[r];
         b1[r*16 +: 16] = b[r];
      end
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 3; c++) m2[(r*3+c)*16 +: 16] = w[r][c];
         b2[r*16 +: 16] = b[r];
      end
      for (int c = 0; c < 4; c++) begin
         v0[c*16 +: 16] = x[c];
         v1[c*16 +: 16] = x[c];
      end
      for (int c = 0; c < 3; c++) v2[c*16 +: 16] = x[c];
      for (int k = 0; k < 3; k++) for (int r = 0; r < 5; r++) o_all[k][r] = '0;
      for (int r = 0; r < 4; r++) begin
         o_all[0][r] = o0[r*16 +: 16];
         o_all[1][r] = o1[r*16 +: 16];
      end
      for (int r = 0; r < 5; r++) o_all[2][r] = o2[r*16 +: 16];
   end

   dense_layer_seq #(.DATA_W(16), .ROWS(4), .COLS(4), .LANES(2), .FRAC(0)) u0 (
      .clk(clk), .rst(rst), .start(st[0]), .ready(rdy[0]), .relu_en(rl[0]), .mat1(m0), .vec(v0),
      .bias(b0), .out(o0), .out_valid(ov[0]), .out_ready(ordy[0]));
   dense_layer_seq #(.DATA_W(16), .ROWS(4), .COLS(4), .LANES(2), .FRAC(8)) u1 (
      .clk(clk), .rst(rst), .start(st[1]), .ready(rdy[1]), .relu_en(rl[1]), .mat1(m1), .vec(v1),
      .bias(b1), .out(o1), .out_valid(ov[1]), .out_ready(ordy[1]));
   dense_layer_seq #(.DATA_W(16), .ROWS(5), .COLS(3), .LANES(2), .FRAC(0)) u2 (
      .clk(clk), .rst(rst), .start(st[2]), .ready(rdy[2]), .relu_en(rl[2]), .mat1(m2), .vec(v2),
      .bias(b2), .out(o2), .out_valid(ov[2]), .out_ready(ordy[2]));

   task automatic chk(input string n, input longint a, input longint e);
      total++;
      if (a != e) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", n, a, e, $time);
      end
   endtask

   function automatic void calc(input int k, input logic relu);
      for (int r = 0; r < 5; r++) begin
         longint acc_v;
         acc_v = 0;
         if (r < RR[k]) begin
            for (int c = 0; c < CC[k]; c++) acc_v += longint'(w[r][c]) * longint'(x[c]);
            acc_v = acc_v + (longint'(b[r]) <<< FF[k]);
            acc_v = acc_v >>> FF[k];
            if (relu && acc_v < 0) acc_v = 0;
            if (acc_v > 32767) acc_v = 32767;
            if (acc_v < -32768) acc_v = -32768;
         end
         pend[k][r] = 16'(acc_v);
      end
   endfunction

   initial begin
      bit a_now, t_now;
      for (int k = 0; k < 3; k++) begin
         busy[k] = 0;
         val[k] = 0;
         cnt[k] = 0;
         for (int r = 0; r < 5; r++) eo[k][r] = '0;
      end
      forever begin
         @(posedge clk);
         for (int k = 0; k < 3; k++) begin
            if (rst) begin
               busy[k] = 0;
               val[k] = 0;
               for (int r = 0; r < 5; r++) eo[k][r] = '0;
            end else begin
               a_now = st[k] && !busy[k] && !val[k];
               t_now = val[k] && ordy[k];
               if (busy[k]) begin
                  if (cnt[k] == 1) begin
                     busy[k] = 0;
                     val[k] = 1;
                     for (int r = 0; r < 5; r++) eo[k][r] = pend[k][r];
                  end
                  cnt[k]--;
               end
               if (t_now) val[k] = 0;
               if (a_now) begin
                  calc(k, rl[k]);
                  busy[k] = 1;
                  cnt[k] = ((RR[k] + LN - 1) / LN) * (CC[k] + 1);
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (armed)
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("ready%0d", k), rdy[k], !busy[k] && !val[k]);
            chk($sformatf("valid%0d", k), ov[k], val[k]);
            if (!busy[k])
               for (int r = 0; r < RR[k]; r++) chk($sformatf("out%0d[%0d]", k, r), o_all[k][r], eo[k][r]);
         end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setex(input longint e0, e1, e2, e3, e4);
      ex[0] = 16'(e0); ex[1] = 16'(e1); ex[2] = 16'(e2); ex[3] = 16'(e3); ex[4] = 16'(e4);
   endtask

   task automatic fill(input logic signed [15:0] wv, xv, bv);
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 4; c++) w[r][c] = wv;
         b[r] = bv;
      end
      for (int c = 0; c < 4; c++) x[c] = xv;
   endtask

   task automatic ident(input logic signed [15:0] one, input logic signed [15:0] x0, x1, x2, x3,
                        input logic signed [15:0] bv);
      fill(16'sd0, 16'sd0, bv);
      for (int r = 0; r < 4; r++) w[r][r] = one;
      x[0] = x0; x[1] = x1; x[2] = x2; x[3] = x3;
   endtask

   task automatic run(input int k, input logic relu, input int hold, input int lat);
      int cyc;
      tick();
      rl[k] = relu;
      st[k] = 1'b1;
      tick();
      st[k] = 1'b0;
      for (int c = 0; c < 4; c++) x[c] = x[c] + 16'sd7;
      cyc = 1;
      forever begin
         @(negedge clk);
         if (ov[k] || cyc >= 400) break;
         @(posedge clk);
         cyc++;
      end
      chk("valid_rise", ov[k], 1);
      if (lat > 0) chk("latency", cyc, lat);
      for (int r = 0; r < RR[k]; r++) begin
         chk($sformatf("result[%0d]", r), o_all[k][r], ex[r]);
         chk($sformatf("model[%0d]", r), eo[k][r], ex[r]);
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1 st[k] = (i == 1);
      end
      st[k] = 1'b0;
      if (hold > 0) begin
         @(negedge clk);
         chk("hold_valid", ov[k], 1);
         chk("hold_ready", rdy[k], 0);
         for (int r = 0; r < RR[k]; r++) chk($sformatf("hold[%0d]", r), o_all[k][r], ex[r]);
      end
      ordy[k] = 1'b1;
      tick();
      ordy[k] = 1'b0;
      @(negedge clk);
      chk("ready_after", rdy[k], 1);
      chk("valid_after", ov[k], 0);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         st[k] = 1'b0;
         ordy[k] = 1'b0;
         rl[k] = 1'b0;
      end
      fill(16'sd0, 16'sd0, 16'sd0);
      ex = '{default: '0};
      rst = 1'b1;
      st[0] = 1'b1;
      tick();
      armed = 1'b1;
      tick();
      tick();
      st[0] = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_ready", rdy[0], 1);
      chk("reset_valid", ov[0], 0);
      chk("reset_out", o_all[0][0], 0);

      ident(16'sd1, 16'sd1, -16'sd2, 16'sd3, -16'sd4, 16'sd0);
      setex(1, 0, 3, 0, 0);
      run(0, 1'b1, 0, 11);
      ident(16'sd1, 16'sd1, -16'sd2, 16'sd3, -16'sd4, 16'sd0);
      setex(1, -2, 3, -4, 0);
      run(0, 1'b0, 0, 11);

      ident(16'sh0100, 16'sh0180, 16'sh0180, 16'sh0180, 16'sh0180, 16'sh0080);
      setex(512, 512, 512, 512, 0);
      run(1, 1'b0, 0, 11);

      fill(16'sd32767, 16'sd32767, 16'sd0);
      setex(32767, 32767, 32767, 32767, 0);
      run(0, 1'b1, 0, 0);
      fill(16'sd32767, -16'sd32767, 16'sd0);
      setex(-32768, -32768, -32768, -32768, 0);
      run(0, 1'b0, 0, 0);

      fill(16'sd1, 16'sd0, 16'sd0);
      x[0] = 16'sd1; x[1] = 16'sd2; x[2] = 16'sd3;
      for (int r = 0; r < 5; r++) b[r] = 16'(r);
      setex(6, 7, 8, 9, 10);
      run(2, 1'b0, 0, 13);

      ident(16'sd1, 16'sd1, -16'sd2, 16'sd3, -16'sd4, 16'sd0);
      setex(1, 0, 3, 0, 0);
      run(0, 1'b1, 5, 11);
      ident(16'sd1, 16'sd1, -16'sd2, 16'sd3, -16'sd4, 16'sd0);
      setex(1, -2, 3, -4, 0);
      run(0, 1'b0, 0, 11);

      ident(16'sd1, 16'sd1, -16'sd2, 16'sd3, -16'sd4, 16'sd0);
      tick();
      rl[0] = 1'b1;
      st[0] = 1'b1;
      tick();
      st[0] = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready", rdy[0], 1);
      chk("abort_valid", ov[0], 0);
      for (int r = 0; r < 4; r++) chk($sformatf("abort_out[%0d]", r), o_all[0][r], 0);
      ident(16'sd1, 16'sd1, -16'sd2, 16'sd3, -16'sd4, 16'sd0);
      setex(1, 0, 3, 0, 0);
      run(0, 1'b1, 0, 11);

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
